// File: rtl/pc_unit.sv
// Fetch-stage program counter: BOOT delay, prioritised redirect (exc > eret > branch > step), EPC save, HALT/resume.
// Optional misaligned-target trap when PC_ALIGN_CHECK_EN is defined; all outputs registered, 1-cycle redirect latency.
module pc_unit #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          STEP      = 4,
  parameter int          BOOT_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              en,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_epc,
  input  logic              eret,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pcAddr,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] epc,
  output logic              misalign
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] EXC_PC  = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(STEP);
  localparam logic [3:0]        BOOT_CT = 4'(BOOT_WAIT);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] pc_n, epc_n, tgt;
  logic              redir;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pcAddr;
    epc_n   = epc;
    redir   = 1'b0;
    tgt     = br_target;
    case (state)
      BOOT: begin
        cnt_n = cnt + 4'd1;
        if (cnt == BOOT_CT) state_n = RUN;
      end
      RUN: begin
        if (exc_req) begin
          pc_n  = EXC_PC;
          epc_n = exc_epc;
        end else if (eret) begin
          redir = 1'b1;
          tgt   = epc;
        end else if (en) begin
          if (br_taken) redir = 1'b1;
          else          pc_n  = pcAddr + STEP_W;
          // halting still advances the PC so wake-up resumes at the next instruction
          if (halt_req) state_n = HALT;
        end
      end
      HALT: begin
        if (exc_req) begin
          pc_n    = EXC_PC;
          epc_n   = exc_epc;
          state_n = RUN;
        end else if (resume) begin
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
`ifdef PC_ALIGN_CHECK_EN
    // a misaligned redirect traps to the handler with the bad address in EPC
    if (redir && (tgt[1:0] != 2'b00)) begin
      pc_n  = EXC_PC;
      epc_n = tgt;
    end else if (redir) begin
      pc_n = tgt;
    end
`else
    if (redir) pc_n = tgt;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= BOOT;
      cnt      <= 4'd0;
      pcAddr   <= RST_PC;
      epc      <= '0;
      pc_valid <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pcAddr   <= pc_n;
      epc      <= epc_n;
      pc_valid <= (state_n == RUN);
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) misalign <= 1'b0;
    else       misalign <= redir && (tgt[1:0] != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with default parameters: boot delay, stall, branch, exception/eret, halt, async reset.
module tb_pc_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        en, br_taken, exc_req, eret, halt_req, resume;
  logic [31:0] br_target, exc_epc;
  logic [31:0] pcAddr, epc;
  logic        pc_valid, misalign;

  int checks = 0;
  int errors = 0;

  pc_unit dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .en       (en),
    .br_taken (br_taken),
    .br_target(br_target),
    .exc_req  (exc_req),
    .exc_epc  (exc_epc),
    .eret     (eret),
    .halt_req (halt_req),
    .resume   (resume),
    .pcAddr   (pcAddr),
    .pc_valid (pc_valid),
    .epc      (epc),
    .misalign (misalign)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; br_taken = 1'b0; exc_req = 1'b0; eret = 1'b0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] pc, input logic vld);
    chk({tag, "_pc"}, pcAddr, pc);
    chk({tag, "_vld"}, {31'd0, pc_valid}, {31'd0, vld});
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    en = 1'b1;
    br_target = 32'h0; exc_epc = 32'h0;
    repeat (2) tick();
    expect_pc("rst", 32'h3000, 1'b0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);

    Reset = 1'b0;
    tick(); expect_pc("boot1", 32'h3000, 1'b0);
    tick(); expect_pc("boot2", 32'h3000, 1'b0);
    tick(); expect_pc("first", 32'h3000, 1'b1);
    tick(); expect_pc("seq1", 32'h3004, 1'b1);
    tick(); expect_pc("seq2", 32'h3008, 1'b1);
    tick(); tick(); expect_pc("seq4", 32'h3010, 1'b1);

    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_pc("stall", 32'h3010, 1'b1);
    end
    en = 1'b1; br_taken = 1'b1; br_target = 32'h3400;
    tick(); expect_pc("br", 32'h3400, 1'b1);
    br_target = 32'h3020;
    tick(); expect_pc("br2", 32'h3020, 1'b1);

    idle(); exc_req = 1'b1; exc_epc = 32'h301C;
    tick(); expect_pc("exc", 32'h4180, 1'b1);
    chk("exc_epc", epc, 32'h301C);
    idle(); en = 1'b1;
    tick(); expect_pc("handler", 32'h4184, 1'b1);
    eret = 1'b1;
    tick(); expect_pc("eret", 32'h301C, 1'b1);

    eret = 1'b1; exc_req = 1'b1; br_taken = 1'b1;
    exc_epc = 32'h5000; br_target = 32'h3400;
    tick(); expect_pc("nest", 32'h4180, 1'b1);
    chk("nest_epc", epc, 32'h5000);

    idle(); en = 1'b1; br_taken = 1'b1; br_target = 32'h3050;
    tick(); expect_pc("to3050", 32'h3050, 1'b1);
    br_taken = 1'b0; halt_req = 1'b1;
    tick(); expect_pc("halt", 32'h3054, 1'b0);
    halt_req = 1'b0; br_taken = 1'b1; br_target = 32'h3400;
    tick(); expect_pc("halt_br", 32'h3054, 1'b0);
    br_taken = 1'b0; resume = 1'b1;
    tick(); expect_pc("resume", 32'h3054, 1'b1);
    resume = 1'b0;
    tick(); expect_pc("after_res", 32'h3058, 1'b1);

    // halt and branch together: branch wins the address, HALT still entered
    halt_req = 1'b1; br_taken = 1'b1; br_target = 32'h3200;
    tick(); expect_pc("halt_brw", 32'h3200, 1'b0);
    idle(); exc_req = 1'b1; exc_epc = 32'h3204;
    tick(); expect_pc("wake_exc", 32'h4180, 1'b1);
    chk("wake_epc", epc, 32'h3204);

    idle(); en = 1'b1; halt_req = 1'b1;
    tick(); expect_pc("halt2", 32'h4184, 1'b0);
    idle(); en = 1'b1;
    #1 Reset = 1'b1;
    #1 expect_pc("async", 32'h3000, 1'b0);
    chk("async_epc", epc, 32'h0);
    #1 Reset = 1'b0;
    tick(); expect_pc("reboot1", 32'h3000, 1'b0);
    tick(); expect_pc("reboot2", 32'h3000, 1'b0);
    tick(); expect_pc("reboot3", 32'h3000, 1'b1);

    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick(); expect_pc("to_top", 32'hFFFF_FFFC, 1'b1);
    br_taken = 1'b0;
    tick(); expect_pc("wrap", 32'h0000_0000, 1'b1);

    br_taken = 1'b1; br_target = 32'h3402;
    tick();
`ifdef PC_ALIGN_CHECK_EN
    expect_pc("mis", 32'h4180, 1'b1);
    chk("mis_epc", epc, 32'h3402);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
`else
    expect_pc("mis", 32'h3402, 1'b1);
    chk("mis_flag", {31'd0, misalign}, 32'd0);
`endif
    br_taken = 1'b0;
    tick();
    chk("mis_clr", {31'd0, misalign}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage and the successor to the single-register PC. It holds the fetch address and selects the next address from prioritised sources: exception vector, exception return, branch/jump target, or sequential increment. It also saves the exception return address in EPC, holds fetch for a programmable boot delay after reset, and supports a halt/resume low-power state. It drives the instruction-memory address and a fetch-valid qualifier to the IF/ID stage.

## Interface
Parameters:
- ADDR_W, 32, address width in bits (≥ 8)
- RESET_VEC, 32'h0000_3000, PC value during and after reset (truncated to ADDR_W)
- EXC_VEC, 32'h0000_4180, exception/interrupt handler entry
- STEP, 4, sequential increment in bytes
- BOOT_WAIT, 2, cycles after reset release before the first valid fetch (0..15)

Ports:
- Clk, in, 1, clock; all state updates on the rising edge
- Reset, in, 1, asynchronous, active-high
- en, in, 1, pipeline advance; 0 = stall (PC holds)
- br_taken, in, 1, branch/jump redirect request
- br_target, in, ADDR_W, branch/jump target
- exc_req, in, 1, exception/interrupt redirect; ignores en
- exc_epc, in, ADDR_W, return address to save on exc_req
- eret, in, 1, exception return; ignores en
- halt_req, in, 1, enter HALT (sampled when en = 1)
- resume, in, 1, leave HALT
- pcAddr, out, ADDR_W, current fetch address (registered)
- pc_valid, out, 1, pcAddr is a real fetch this cycle
- epc, out, ADDR_W, saved exception return address
- misalign, out, 1, misaligned-redirect pulse (only when PC_ALIGN_CHECK_EN is defined; otherwise tied 0)

## Operation
- States: BOOT, RUN, HALT. A 4-bit boot counter supports BOOT_WAIT.
- Reset asserted: state = BOOT, counter = 0, pcAddr = RESET_VEC, epc = 0, pc_valid = 0, misalign = 0.
- BOOT:
  - pcAddr holds and all requests are ignored.
  - The counter increments each cycle. When counter == BOOT_WAIT, the next state is RUN.
  - BOOT_WAIT = 0 means RUN on the first edge after reset release.
- RUN: the next PC is selected in fixed priority.
  1. exc_req: pcAddr ← EXC_VEC, epc ← exc_epc.
  2. eret: pcAddr ← epc.
  3. en && br_taken: pcAddr ← br_target.
  4. en: pcAddr ← pcAddr + STEP, modulo 2^ADDR_W. All-ones wraps to STEP−1 style low values with no flag.
  5. Otherwise pcAddr holds.
- halt_req with en = 1 and no exc_req/eret:
  - The next state is HALT.
  - pcAddr still takes its normal priority-4 update, so HALT resumes at the next instruction.
  - br_taken in the same cycle wins the address, and HALT is still entered.
- HALT:
  - pcAddr holds; pc_valid = 0.
  - resume → RUN.
  - exc_req → RUN with priority-1 update (interrupt wake).
  - eret, br_taken and halt_req are ignored.
- exc_req and eret together: exc_req wins and epc is overwritten. This is nested exception behaviour.
- pc_valid = 1 only in RUN.

## Timing
- Every pcAddr, epc and state change is visible one cycle after the request edge. No combinational path runs from inputs to outputs.
- Redirect latency is 1 cycle. An instruction fetched with a redirect pending is squashed by the pipeline, not by this block.
- Reset mid-operation forces BOOT and reset values immediately (asynchronous), and the boot delay restarts.
- First valid fetch: pc_valid rises at edge BOOT_WAIT+1 after Reset falls, with pcAddr = RESET_VEC.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - Any br_target or eret address with bits [1:0] ≠ 0 is not loaded.
  - Instead: pcAddr ← EXC_VEC, epc ← the offending address, misalign = 1 for exactly one cycle.
  - exc_req is unaffected.
- PC_ALIGN_CHECK_EN undefined:
  - Targets are loaded unchanged and no check logic is built.
  - misalign is constant 0.

## Test plan
- Reset release, BOOT_WAIT = 2, en = 1 held → pc_valid 0 for edges 1–2, rises at edge 3 with pcAddr = 0x3000, then 0x3004, 0x3008.
- At pcAddr 0x3010: en = 0 for 3 cycles, then en = 1 with br_taken, br_target = 0x3400 → PC holds 0x3010 for 3 cycles, then becomes 0x3400.
- In RUN at 0x3020: exc_req + exc_epc = 0x301C with en = 0 → pcAddr = 0x4180, epc = 0x301C; later eret → pcAddr = 0x301C.
- exc_req, eret and br_taken in one cycle → pcAddr = EXC_VEC, epc = exc_epc.
- halt_req at 0x3050 → HALT with pcAddr 0x3054 and pc_valid 0; br_taken in HALT ignored; resume → RUN fetching 0x3054. Asynchronous Reset pulse mid-HALT → pcAddr 0x3000 immediately, BOOT restarts.
- With PC_ALIGN_CHECK_EN: br_target = 0x3402 → pcAddr 0x4180, epc 0x3402, misalign pulses for 1 cycle. Without the macro: pcAddr = 0x3402 and misalign stays 0.
